// File: rtl/camera_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : camera_config_sequencer
// Brief    : Camera bring-up sequencer sharing the SCCB/I2C bus between the
//            ROM-driven init load and queued runtime single-register writes.
// Options  : CAM_SEQ_RUNTIME_WR_EN builds the runtime write FIFO/engine path.
// Revision : 1.0 - initial release
// ============================================================================
module camera_config_sequencer #(
    parameter int unsigned POWERUP_CYCLES = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 16777216,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clk_camera,
    input  logic        sys_rst_camera,
    input  logic        cfg_restart,
    output logic        cr_init_valid,
    input  logic        cr_init_ready,
    input  logic        bus_active,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        eng_valid,
    input  logic        eng_ready,
    output logic [15:0] eng_addr,
    output logic [7:0]  eng_data,
    input  logic        eng_done,
    input  logic        eng_nack,
    output logic        config_done,
    output logic        config_error,
    output logic [1:0]  retry_count,
    output logic [7:0]  nack_count
);

    localparam int unsigned c_TIMER_MAX = (POWERUP_CYCLES > TIMEOUT_CYCLES) ?
                                          POWERUP_CYCLES : TIMEOUT_CYCLES;
    localparam int          c_TIMER_W   = $clog2(c_TIMER_MAX + 1);
    localparam logic [c_TIMER_W-1:0] c_PWR_LAST = c_TIMER_W'(POWERUP_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TO_LAST  = c_TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PWR_WAIT  = 3'd0,
        ST_INIT_REQ  = 3'd1,
        ST_INIT_BUSY = 3'd2,
        ST_IDLE      = 3'd3,
        ST_WR_ISSUE  = 3'd4,
        ST_WR_WAIT   = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_TIMER_W-1:0]   r_timer;
    logic                   r_seen_active;
    logic                   r_cr_init_valid;
    logic                   r_config_done;
    logic                   r_config_error;
    logic [1:0]             r_retry_count;

    logic                   w_restart;
    logic                   w_timeout;
    logic                   w_init_done;
    logic                   w_retry_left;
    logic                   w_counting;

    assign w_restart    = cfg_restart && ((r_state == ST_IDLE) || (r_state == ST_FAULT));
    assign w_timeout    = (r_timer == c_TO_LAST);
    assign w_init_done  = (r_state == ST_INIT_BUSY) && r_seen_active &&
                          !bus_active && cr_init_ready;
    assign w_retry_left = (32'(r_retry_count) < MAX_RETRIES);
    assign w_counting   = (r_state == ST_PWR_WAIT) || (r_state == ST_INIT_BUSY) ||
                          (r_state == ST_WR_WAIT);

`ifdef CAM_SEQ_RUNTIME_WR_EN
    logic w_fifo_empty;
    logic r_eng_valid;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_PWR_WAIT: begin
                if (r_timer == c_PWR_LAST) begin
                    w_state_next = ST_INIT_REQ;
                end
            end
            ST_INIT_REQ: begin
                if (r_cr_init_valid && cr_init_ready) begin
                    w_state_next = ST_INIT_BUSY;
                end
            end
            ST_INIT_BUSY: begin
                if (w_init_done) begin
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_next = w_retry_left ? ST_PWR_WAIT : ST_FAULT;
                end
            end
            ST_IDLE: begin
                if (cfg_restart) begin
                    w_state_next = ST_PWR_WAIT;
                end
`ifdef CAM_SEQ_RUNTIME_WR_EN
                else if (!w_fifo_empty) begin
                    w_state_next = ST_WR_ISSUE;
                end
`endif
            end
`ifdef CAM_SEQ_RUNTIME_WR_EN
            ST_WR_ISSUE: begin
                if (r_eng_valid && eng_ready) begin
                    w_state_next = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (eng_done || w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            ST_FAULT: begin
                if (cfg_restart) begin
                    w_state_next = ST_PWR_WAIT;
                end
            end
            default: begin
                w_state_next = ST_PWR_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            r_state <= ST_PWR_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One shared timer: cleared on every state change, runs only in the waiting states.
    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            r_timer         <= '0;
            r_seen_active   <= 1'b0;
            r_cr_init_valid <= 1'b0;
            r_config_done   <= 1'b0;
            r_config_error  <= 1'b0;
            r_retry_count   <= 2'd0;
        end else begin
            if (w_state_next != r_state) begin
                r_timer <= '0;
            end else if (w_counting) begin
                r_timer <= r_timer + c_TIMER_W'(1);
            end

            r_cr_init_valid <= (w_state_next == ST_INIT_REQ);
            r_config_error  <= (w_state_next == ST_FAULT);

            if ((r_state == ST_INIT_REQ) && (w_state_next == ST_INIT_BUSY)) begin
                r_seen_active <= 1'b0;
            end else if ((r_state == ST_INIT_BUSY) && bus_active) begin
                r_seen_active <= 1'b1;
            end

            if (w_restart) begin
                r_config_done <= 1'b0;
                r_retry_count <= 2'd0;
            end else if (w_init_done) begin
                r_config_done <= 1'b1;
            end else if ((r_state == ST_INIT_BUSY) && w_timeout && w_retry_left &&
                         (r_retry_count != 2'd3)) begin
                r_retry_count <= r_retry_count + 2'd1;
            end
        end
    end

    assign cr_init_valid = r_cr_init_valid;
    assign config_done   = r_config_done;
    assign config_error  = r_config_error;
    assign retry_count   = r_retry_count;

`ifdef CAM_SEQ_RUNTIME_WR_EN
    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_CNT_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    logic [15:0]        r_fifo_addr [FIFO_DEPTH];
    logic [7:0]         r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [15:0]        r_eng_addr;
    logic [7:0]         r_eng_data;
    logic [7:0]         r_nack_count;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_nack_inc;

    assign w_full       = (r_count == c_CNT_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = wr_valid && !w_full;
    assign w_pop        = (r_state == ST_IDLE) && (w_state_next == ST_WR_ISSUE);
    assign w_nack_inc   = (r_state == ST_WR_WAIT) &&
                          (eng_done ? eng_nack : w_timeout);

    always_ff @(posedge clk_camera) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_eng_valid  <= 1'b0;
            r_eng_addr   <= 16'd0;
            r_eng_data   <= 8'd0;
            r_nack_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
                r_eng_addr <= r_fifo_addr[r_rd_ptr];
                r_eng_data <= r_fifo_data[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase

            // The first WR_ISSUE cycle is a setup cycle: address/data settle before valid.
            r_eng_valid <= (r_state == ST_WR_ISSUE) && (w_state_next == ST_WR_ISSUE);

            if (w_nack_inc && (r_nack_count != 8'hFF)) begin
                r_nack_count <= r_nack_count + 8'd1;
            end
        end
    end

    assign wr_ready   = !w_full;
    assign eng_valid  = r_eng_valid;
    assign eng_addr   = r_eng_addr;
    assign eng_data   = r_eng_data;
    assign nack_count = r_nack_count;
`else
    logic w_unused_inputs;
    assign w_unused_inputs = ^{wr_valid, wr_addr, wr_data, eng_ready, eng_done, eng_nack};

    assign wr_ready   = 1'b0;
    assign eng_valid  = 1'b0;
    assign eng_addr   = 16'd0;
    assign eng_data   = 8'd0;
    assign nack_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_camera_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_camera_config_sequencer
// Brief    : Directed bench for camera_config_sequencer (POWERUP=16, TIMEOUT=64);
//            runtime-write scenarios are built when CAM_SEQ_RUNTIME_WR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_camera_config_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_restart = 1'b0;
    logic        cr_init_valid;
    logic        cr_init_ready = 1'b1;
    logic        bus_active = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_addr = 16'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        eng_valid;
    logic        eng_ready = 1'b0;
    logic [15:0] eng_addr;
    logic [7:0]  eng_data;
    logic        eng_done = 1'b0;
    logic        eng_nack = 1'b0;
    logic        config_done;
    logic        config_error;
    logic [1:0]  retry_count;
    logic [7:0]  nack_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   edge_n = -1;
    logic ev_seen = 1'b0;
    logic wr_seen = 1'b0;

`ifdef CAM_SEQ_RUNTIME_WR_EN
    localparam logic c_EXP_WR_READY = 1'b1;
`else
    localparam logic c_EXP_WR_READY = 1'b0;
`endif

    camera_config_sequencer #(
        .POWERUP_CYCLES (16),
        .TIMEOUT_CYCLES (64),
        .MAX_RETRIES    (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk_camera     (clk),
        .sys_rst_camera (rst),
        .cfg_restart    (cfg_restart),
        .cr_init_valid  (cr_init_valid),
        .cr_init_ready  (cr_init_ready),
        .bus_active     (bus_active),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .eng_valid      (eng_valid),
        .eng_ready      (eng_ready),
        .eng_addr       (eng_addr),
        .eng_data       (eng_data),
        .eng_done       (eng_done),
        .eng_nack       (eng_nack),
        .config_done    (config_done),
        .config_error   (config_error),
        .retry_count    (retry_count),
        .nack_count     (nack_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Advance one rising edge and settle; edge_n numbers edges from reset release.
    task tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (eng_valid) ev_seen = 1'b1;
        if (wr_ready)  wr_seen = 1'b1;
    endtask

    task tick_to(input int n);
        while (edge_n < n) tick();
    endtask

    task do_reset();
        rst = 1'b1;
        cfg_restart = 1'b0; cr_init_ready = 1'b1; bus_active = 1'b0;
        wr_valid = 1'b0; eng_ready = 1'b0; eng_done = 1'b0; eng_nack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        edge_n = -1;
    endtask

    // Handshake lands on edge 17; bus_active for 10 cycles then completion on edge 28.
    task complete_init();
        tick_to(17);
        bus_active = 1'b1;
        repeat (10) tick();
        bus_active = 1'b0;
        tick();
    endtask

    task automatic drain_one(input logic nack, output logic got,
                             output logic [15:0] a, output logic [7:0] d);
        got = 1'b0; a = 16'd0; d = 8'd0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (eng_valid) got = 1'b1;
            else tick();
        end
        if (got) begin
            a = eng_addr; d = eng_data;
            eng_ready = 1'b1; tick(); eng_ready = 1'b0;
            eng_done = 1'b1; eng_nack = nack; tick();
            eng_done = 1'b0; eng_nack = 1'b0;
        end
    endtask

    task test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (cr_init_valid !== 1'b0) begin n_err++; $display("FAIL reset_init_valid got=%b exp=0", cr_init_valid); end
        n_vec++; if (eng_valid !== 1'b0) begin n_err++; $display("FAIL reset_eng_valid got=%b exp=0", eng_valid); end
        n_vec++; if (config_done !== 1'b0) begin n_err++; $display("FAIL reset_config_done got=%b exp=0", config_done); end
        n_vec++; if (config_error !== 1'b0) begin n_err++; $display("FAIL reset_config_error got=%b exp=0", config_error); end
        n_vec++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL reset_retry_count got=%0d exp=0", retry_count); end
        n_vec++; if (nack_count !== 8'd0) begin n_err++; $display("FAIL reset_nack_count got=%0d exp=0", nack_count); end
        n_vec++; if (eng_addr !== 16'd0 || eng_data !== 8'd0) begin n_err++; $display("FAIL reset_eng_bus got=%h/%h exp=0000/00", eng_addr, eng_data); end
        n_vec++; if (wr_ready !== c_EXP_WR_READY) begin n_err++; $display("FAIL reset_wr_ready got=%b exp=%b", wr_ready, c_EXP_WR_READY); end
        rst = 1'b0;
        edge_n = -1;
    endtask

    task test_bringup();
        do_reset();
        ev_seen = 1'b0;
        tick_to(15);
        n_vec++; if (cr_init_valid !== 1'b0) begin n_err++; $display("FAIL bringup_valid_e15 got=%b exp=0", cr_init_valid); end
        tick();
        n_vec++; if (cr_init_valid !== 1'b1) begin n_err++; $display("FAIL bringup_valid_e16 got=%b exp=1", cr_init_valid); end
        tick();
        n_vec++; if (cr_init_valid !== 1'b0) begin n_err++; $display("FAIL bringup_valid_drop got=%b exp=0", cr_init_valid); end
        bus_active = 1'b1;
        repeat (10) tick();
        n_vec++; if (config_done !== 1'b0) begin n_err++; $display("FAIL bringup_done_early got=%b exp=0", config_done); end
        bus_active = 1'b0;
        tick();
        n_vec++; if (config_done !== 1'b1) begin n_err++; $display("FAIL bringup_done got=%b exp=1", config_done); end
        n_vec++; if (retry_count !== 2'd0 || config_error !== 1'b0) begin n_err++; $display("FAIL bringup_status got=retry%0d err%b exp=retry0 err0", retry_count, config_error); end
        n_vec++; if (ev_seen !== 1'b0) begin n_err++; $display("FAIL bringup_no_eng got=%b exp=0", ev_seen); end
    endtask

    task test_retry_fault();
        int e;
        do_reset();
        tick_to(80);
        n_vec++; if (retry_count !== 2'd0) begin n_err++; $display("FAIL retry_e80 got=%0d exp=0", retry_count); end
        tick_to(81);
        n_vec++; if (retry_count !== 2'd1) begin n_err++; $display("FAIL retry_e81 got=%0d exp=1", retry_count); end
        tick_to(97);
        n_vec++; if (cr_init_valid !== 1'b0) begin n_err++; $display("FAIL retry_pwr_wait got=%b exp=0", cr_init_valid); end
        tick_to(98);
        n_vec++; if (cr_init_valid !== 1'b1) begin n_err++; $display("FAIL retry_reinit got=%b exp=1", cr_init_valid); end
        tick_to(162);
        n_vec++; if (retry_count !== 2'd1) begin n_err++; $display("FAIL retry_e162 got=%0d exp=1", retry_count); end
        tick_to(163);
        n_vec++; if (retry_count !== 2'd2) begin n_err++; $display("FAIL retry_e163 got=%0d exp=2", retry_count); end
        tick_to(245);
        n_vec++; if (retry_count !== 2'd3) begin n_err++; $display("FAIL retry_e245 got=%0d exp=3", retry_count); end
        tick_to(326);
        n_vec++; if (config_error !== 1'b0) begin n_err++; $display("FAIL fault_early got=%b exp=0", config_error); end
        tick_to(327);
        n_vec++; if (config_error !== 1'b1 || retry_count !== 2'd3) begin n_err++; $display("FAIL fault_enter got=err%b retry%0d exp=err1 retry3", config_error, retry_count); end
        tick_to(400);
        n_vec++; if (config_error !== 1'b1 || cr_init_valid !== 1'b0) begin n_err++; $display("FAIL fault_hold got=err%b valid%b exp=err1 valid0", config_error, cr_init_valid); end
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
        e = edge_n;
        n_vec++; if (retry_count !== 2'd0 || config_error !== 1'b0 || config_done !== 1'b0) begin n_err++; $display("FAIL restart_clear got=retry%0d err%b done%b exp=0/0/0", retry_count, config_error, config_done); end
        tick_to(e + 16);
        n_vec++; if (cr_init_valid !== 1'b0) begin n_err++; $display("FAIL restart_pwr_wait got=%b exp=0", cr_init_valid); end
        tick_to(e + 17);
        n_vec++; if (cr_init_valid !== 1'b1) begin n_err++; $display("FAIL restart_reinit got=%b exp=1", cr_init_valid); end
    endtask

`ifdef CAM_SEQ_RUNTIME_WR_EN
    task test_queued_during_init();
        logic got; logic [15:0] a; logic [7:0] d;
        do_reset();
        ev_seen = 1'b0;
        tick_to(17);
        bus_active = 1'b1;
        wr_valid = 1'b1; wr_addr = 16'h3500; wr_data = 8'h12;
        tick();
        wr_addr = 16'h3501; wr_data = 8'h34;
        tick();
        wr_valid = 1'b0;
        tick_to(27);
        bus_active = 1'b0;
        tick();
        n_vec++; if (config_done !== 1'b1 || ev_seen !== 1'b0) begin n_err++; $display("FAIL queued_gated got=done%b eng%b exp=done1 eng0", config_done, ev_seen); end
        tick();
        n_vec++; if (eng_valid !== 1'b0) begin n_err++; $display("FAIL queued_setup got=%b exp=0", eng_valid); end
        tick();
        n_vec++; if (eng_valid !== 1'b1 || eng_addr !== 16'h3500 || eng_data !== 8'h12) begin n_err++; $display("FAIL queued_first got=%b %h/%h exp=1 3500/12", eng_valid, eng_addr, eng_data); end
        repeat (3) tick();
        n_vec++; if (eng_valid !== 1'b1 || eng_addr !== 16'h3500 || eng_data !== 8'h12) begin n_err++; $display("FAIL queued_hold got=%b %h/%h exp=1 3500/12", eng_valid, eng_addr, eng_data); end
        eng_ready = 1'b1; tick(); eng_ready = 1'b0;
        n_vec++; if (eng_valid !== 1'b0) begin n_err++; $display("FAIL queued_hs_drop got=%b exp=0", eng_valid); end
        eng_done = 1'b1; tick(); eng_done = 1'b0;
        tick();
        n_vec++; if (eng_valid !== 1'b0) begin n_err++; $display("FAIL queued_done_m1 got=%b exp=0", eng_valid); end
        tick();
        n_vec++; if (eng_valid !== 1'b1 || eng_addr !== 16'h3501 || eng_data !== 8'h34) begin n_err++; $display("FAIL queued_second got=%b %h/%h exp=1 3501/34", eng_valid, eng_addr, eng_data); end
        drain_one(1'b0, got, a, d);
        tick();
        n_vec++; if (nack_count !== 8'd0 || eng_valid !== 1'b0) begin n_err++; $display("FAIL queued_ack got=nack%0d eng%b exp=nack0 eng0", nack_count, eng_valid); end
    endtask

    task test_fifo_full();
        logic got; logic [15:0] a; logic [7:0] d;
        do_reset();
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_addr = 16'h4000 + 16'(i);
            wr_data = 8'hA0 + 8'(i);
            tick();
            if (i == 2) begin
                n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL full_after3 got=%b exp=1", wr_ready); end
            end
            if (i == 3) begin
                n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_after4 got=%b exp=0", wr_ready); end
            end
        end
        wr_valid = 1'b0;
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL full_after5 got=%b exp=0", wr_ready); end
        complete_init();
        for (int i = 0; i < 4; i++) begin
            drain_one(1'b0, got, a, d);
            n_vec++; if (got !== 1'b1 || a !== 16'h4000 + 16'(i) || d !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL full_drain%0d got=%b %h/%h exp=1 %h/%h", i, got, a, d, 16'h4000 + 16'(i), 8'hA0 + 8'(i)); end
        end
        drain_one(1'b0, got, a, d);
        n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL full_fifth_dropped got=%b exp=0", got); end
    endtask

    task test_nack_timeout();
        logic got; logic [15:0] a; logic [7:0] d;
        int hs; int waited;
        do_reset();
        wr_valid = 1'b1; wr_addr = 16'h1000; wr_data = 8'h11; tick();
        wr_addr = 16'h1001; wr_data = 8'h22; tick();
        wr_valid = 1'b0;
        complete_init();
        drain_one(1'b1, got, a, d);
        n_vec++; if (got !== 1'b1 || a !== 16'h1000 || nack_count !== 8'd1) begin n_err++; $display("FAIL nack_first got=%b %h nack%0d exp=1 1000 nack1", got, a, nack_count); end
        for (int i = 0; i < 20 && !eng_valid; i++) tick();
        eng_ready = 1'b1; tick(); eng_ready = 1'b0;
        hs = edge_n;
        for (int i = 0; i < 100 && nack_count == 8'd1; i++) tick();
        waited = edge_n - hs;
        n_vec++; if (nack_count !== 8'd2 || waited != 64) begin n_err++; $display("FAIL timeout_nack got=nack%0d after%0d exp=nack2 after64", nack_count, waited); end
        wr_valid = 1'b1; wr_addr = 16'h2000; wr_data = 8'h5A; tick();
        wr_valid = 1'b0;
        tick();
        n_vec++; if (eng_valid !== 1'b0) begin n_err++; $display("FAIL idle_push_n1 got=%b exp=0", eng_valid); end
        tick();
        n_vec++; if (eng_valid !== 1'b1 || eng_addr !== 16'h2000 || eng_data !== 8'h5A) begin n_err++; $display("FAIL idle_push_n2 got=%b %h/%h exp=1 2000/5a", eng_valid, eng_addr, eng_data); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (eng_valid !== 1'b0 || nack_count !== 8'd0 || eng_addr !== 16'd0 || config_done !== 1'b0 || wr_ready !== 1'b1) begin n_err++; $display("FAIL async_reset got=v%b n%0d a%h d%b r%b exp=v0 n0 a0000 d0 r1", eng_valid, nack_count, eng_addr, config_done, wr_ready); end
        tick();
        rst = 1'b0;
        edge_n = -1;
    endtask
`else
    task test_macro_off();
        do_reset();
        ev_seen = 1'b0; wr_seen = 1'b0;
        wr_valid = 1'b1; wr_addr = 16'h3500; wr_data = 8'h12;
        eng_ready = 1'b1; eng_done = 1'b1; eng_nack = 1'b1;
        complete_init();
        n_vec++; if (config_done !== 1'b1) begin n_err++; $display("FAIL off_done got=%b exp=1", config_done); end
        repeat (20) tick();
        n_vec++; if (ev_seen !== 1'b0) begin n_err++; $display("FAIL off_eng_valid got=%b exp=0", ev_seen); end
        n_vec++; if (wr_seen !== 1'b0) begin n_err++; $display("FAIL off_wr_ready got=%b exp=0", wr_seen); end
        n_vec++; if (eng_addr !== 16'd0 || eng_data !== 8'd0 || nack_count !== 8'd0) begin n_err++; $display("FAIL off_ties got=%h/%h n%0d exp=0000/00 n0", eng_addr, eng_data, nack_count); end
        wr_valid = 1'b0; eng_ready = 1'b0; eng_done = 1'b0; eng_nack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_bringup();
        test_retry_fault();
`ifdef CAM_SEQ_RUNTIME_WR_EN
        test_queued_during_init();
        test_fifo_full();
        test_nack_timeout();
`else
        test_macro_off();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
